// File: rtl/mpf_rd_req_arb_if.sv
// Client request / MPF c0 Tx bundle for the read-request arbiter.
// slave: arbiter side; master: clients plus channel side.
interface mpf_rd_req_arb_if #(
  parameter int unsigned N_CLIENTS   = 4,
  parameter int unsigned ADDR_WIDTH  = 42,
  parameter int unsigned MDATA_WIDTH = 16
);
  localparam int unsigned CLIENT_W = $clog2(N_CLIENTS);

  logic [N_CLIENTS-1:0]             req_valid;
  logic [N_CLIENTS*ADDR_WIDTH-1:0]  req_addr;
  logic [N_CLIENTS*MDATA_WIDTH-1:0] req_mdata;
  logic [N_CLIENTS-1:0]             req_grant;
  logic                             tx_almostFull;
  logic                             tx_valid;
  logic [ADDR_WIDTH-1:0]            tx_addr;
  logic [MDATA_WIDTH-1:0]           tx_mdata;
  logic [CLIENT_W-1:0]              tx_client;
  logic                             rsp_eop;

  modport master (
    output req_valid, req_addr, req_mdata, tx_almostFull, rsp_eop,
    input  req_grant, tx_valid, tx_addr, tx_mdata, tx_client
  );

  modport slave (
    input  req_valid, req_addr, req_mdata, tx_almostFull, rsp_eop,
    output req_grant, tx_valid, tx_addr, tx_mdata, tx_client
  );
endinterface

// File: rtl/mpf_rd_req_arb.sv
// Round-robin arbiter for the MPF c0 read-request channel with outstanding-read limit and drain handshake.
// Optional per-client grant statistics built when MPF_RD_ARB_STATS_EN is defined.
module mpf_rd_req_arb #(
  parameter int unsigned N_CLIENTS       = 4,
  parameter int unsigned MAX_ACTIVE_REQS = 512,
  parameter int unsigned ADDR_WIDTH      = 42,
  parameter int unsigned MDATA_WIDTH     = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  mpf_rd_req_arb_if.slave                    bus,
  input  logic                               drain_req,
  output logic                               drain_done,
  output logic [$clog2(MAX_ACTIVE_REQS):0]   active_cnt,
  output logic                               err_underflow,
  output logic [N_CLIENTS*32-1:0]            stat_grant_cnt
);
  localparam int unsigned CLIENT_W = $clog2(N_CLIENTS);
  localparam int unsigned CNT_W    = $clog2(MAX_ACTIVE_REQS) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t               state, state_nxt;
  logic [CLIENT_W-1:0]  ptr, ptr_nxt, win;
  logic                 win_found;
  logic                 grant_ok;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 underflow;

  logic [ADDR_WIDTH-1:0]  addr_arr  [N_CLIENTS];
  logic [MDATA_WIDTH-1:0] mdata_arr [N_CLIENTS];

  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign mdata_arr[g] = bus.req_mdata[g*MDATA_WIDTH +: MDATA_WIDTH];
  end

  // First valid client searching upward from ptr, wrapping at N_CLIENTS.
  always_comb begin
    logic [CLIENT_W:0] idx;
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      idx = {1'b0, ptr} + (CLIENT_W+1)'(i);
      if (idx >= (CLIENT_W+1)'(N_CLIENTS)) idx = idx - (CLIENT_W+1)'(N_CLIENTS);
      if (!win_found && bus.req_valid[idx[CLIENT_W-1:0]]) begin
        win       = idx[CLIENT_W-1:0];
        win_found = 1'b1;
      end
    end
  end

  // A request already registered on tx counts against the outstanding limit.
  always_comb begin
    grant_ok = !reset && (state == RUN) && !drain_req && !bus.tx_almostFull && win_found &&
               (((CNT_W+1)'(active_cnt) + (CNT_W+1)'(bus.tx_valid)) < (CNT_W+1)'(MAX_ACTIVE_REQS));
    bus.req_grant = '0;
    if (grant_ok) bus.req_grant[win] = 1'b1;
    ptr_nxt = ptr;
    if (grant_ok) ptr_nxt = (win == CLIENT_W'(N_CLIENTS-1)) ? '0 : win + CLIENT_W'(1);
  end

  always_comb begin
    cnt_nxt   = active_cnt;
    underflow = 1'b0;
    if (bus.tx_valid && !bus.rsp_eop) begin
      cnt_nxt = active_cnt + CNT_W'(1);
    end else if (!bus.tx_valid && bus.rsp_eop) begin
      if (active_cnt == '0) underflow = 1'b1;
      else                  cnt_nxt   = active_cnt - CNT_W'(1);
    end
  end

  // Drained is judged on the post-update count so drain_done follows the last response by one cycle.
  always_comb begin
    state_nxt  = state;
    drain_done = 1'b0;
    case (state)
      RUN:     if (drain_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!drain_req)                               state_nxt = RUN;
        else if ((cnt_nxt == '0) && !bus.tx_valid)    state_nxt = DRAINED;
      end
      DRAINED: begin
        drain_done = drain_req;
        if (!drain_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      ptr           <= '0;
      active_cnt    <= '0;
      err_underflow <= 1'b0;
      bus.tx_valid  <= 1'b0;
      bus.tx_addr   <= '0;
      bus.tx_mdata  <= '0;
      bus.tx_client <= '0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      active_cnt   <= cnt_nxt;
      bus.tx_valid <= grant_ok;
      if (underflow) err_underflow <= 1'b1;
      if (grant_ok) begin
        bus.tx_addr   <= addr_arr[win];
        bus.tx_mdata  <= mdata_arr[win];
        bus.tx_client <= win;
      end
    end
  end

`ifdef MPF_RD_ARB_STATS_EN
  logic [31:0] stat_q [N_CLIENTS];

  // Saturating per-client grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CLIENTS; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CLIENTS; i++) begin
        if (bus.req_grant[i] && (stat_q[i] != 32'hFFFF_FFFF)) stat_q[i] <= stat_q[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_stat
    assign stat_grant_cnt[g*32 +: 32] = stat_q[g];
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mpf_rd_req_arb.sv
// Randomized scoreboard bench for mpf_rd_req_arb against a cycle-level reference model.
module tb_mpf_rd_req_arb;
  localparam int unsigned N   = 4;
  localparam int unsigned MAX = 8;
  localparam int unsigned AW  = 42;
  localparam int unsigned MW  = 16;
  localparam int unsigned CW  = $clog2(MAX) + 1;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          drain_req;
  logic          drain_done;
  logic [CW-1:0] active_cnt;
  logic          err_underflow;
  logic [N*32-1:0] stat_grant_cnt;

  mpf_rd_req_arb_if #(.N_CLIENTS(N), .ADDR_WIDTH(AW), .MDATA_WIDTH(MW)) bus ();

  mpf_rd_req_arb #(.N_CLIENTS(N), .MAX_ACTIVE_REQS(MAX), .ADDR_WIDTH(AW), .MDATA_WIDTH(MW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .drain_req      (drain_req),
    .drain_done     (drain_done),
    .active_cnt     (active_cnt),
    .err_underflow  (err_underflow),
    .stat_grant_cnt (stat_grant_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   client;
    logic [AW-1:0] addr;
    logic [MW-1:0] mdata;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;

  // reference model state (value held by the DUT during the current cycle)
  int          m_ptr, m_cnt, m_mode;
  bit          m_txp, m_err;
  int unsigned m_stat [N];
  logic [N-1:0] last_gnt;

  bit          allowed, old_txp;
  int          win;
  logic [N-1:0] eg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model and per-cycle output checks
  always @(negedge clk) begin
    if (reset) begin
      m_ptr = 0; m_cnt = 0; m_mode = M_RUN; m_txp = 0; m_err = 0;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
      last_gnt = '0;
      sb.delete();
    end else begin
      allowed = (m_mode == M_RUN) && !drain_req && !bus.tx_almostFull &&
                (m_cnt + int'(m_txp) < int'(MAX)) && (bus.req_valid != '0);
      win = -1;
      if (allowed) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (win < 0 && bus.req_valid[c]) win = c;
        end
      end
      eg = '0;
      if (allowed) eg[win] = 1'b1;

      chk("req_grant", 64'(bus.req_grant), 64'(eg));
      chk("tx_valid", 64'(bus.tx_valid), 64'(m_txp));
      chk("active_cnt", 64'(active_cnt), 64'(m_cnt));
      chk("drain_done", 64'(drain_done), 64'((m_mode == M_DRAINED) && drain_req));
      chk("err_underflow", 64'(err_underflow), 64'(m_err));
      for (int i = 0; i < N; i++)
        chk($sformatf("stat%0d", i), 64'(stat_grant_cnt[i*32 +: 32]), 64'(m_stat[i]));

      if (allowed) begin
        exp_t e;
        e.client = win;
        e.addr   = bus.req_addr[win*AW +: AW];
        e.mdata  = bus.req_mdata[win*MW +: MW];
        sb.push_back(e);
        m_ptr = (win + 1) % N;
`ifdef MPF_RD_ARB_STATS_EN
        if (m_stat[win] != 32'hFFFF_FFFF) m_stat[win]++;
`endif
      end

      old_txp = m_txp;
      if (m_txp && !bus.rsp_eop) m_cnt++;
      else if (!m_txp && bus.rsp_eop) begin
        if (m_cnt == 0) m_err = 1;
        else            m_cnt--;
      end

      case (m_mode)
        M_RUN:     if (drain_req) m_mode = M_DRAIN;
        M_DRAIN:   if (!drain_req) m_mode = M_RUN;
                   else if (m_cnt == 0 && !old_txp) m_mode = M_DRAINED;
        default:   if (!drain_req) m_mode = M_RUN;
      endcase

      m_txp    = allowed;
      last_gnt = eg;
    end
  end

  // Monitor: every issued request must match the oldest expected grant
  always @(negedge clk) begin
    if (!reset && bus.tx_valid) begin
      if (sb.size() == 0) begin
        chk("tx_unexpected", 64'(bus.tx_valid), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tx_client", 64'(bus.tx_client), 64'(e.client));
        chk("tx_addr", 64'(bus.tx_addr), 64'(e.addr));
        chk("tx_mdata", 64'(bus.tx_mdata), 64'(e.mdata));
      end
    end
  end

  // Advance one cycle; granted or idle clients in mask re-request with probability pct.
  task automatic step(input int pct, input logic [N-1:0] mask);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (last_gnt[i] || !bus.req_valid[i]) begin
        if (mask[i] && ($urandom_range(99) < pct)) begin
          bus.req_valid[i]         = 1'b1;
          bus.req_addr[i*AW +: AW] = AW'({$urandom, $urandom});
          bus.req_mdata[i*MW +: MW] = MW'($urandom);
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  // Return every outstanding request and let held requests complete.
  task automatic flush();
    int n;
    n = 0;
    drain_req = 0;
    bus.tx_almostFull = 0;
    while ((m_cnt != 0 || m_txp || bus.req_valid != '0) && n < 200) begin
      bus.rsp_eop = (m_cnt != 0);
      step(0, '0);
      n++;
    end
    bus.rsp_eop = 0;
    if (n >= 200) chk("flush_timeout", 64'(m_cnt), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; drain_req = 0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_mdata = '0;
    bus.tx_almostFull = 0; bus.rsp_eop = 0;
    repeat (3) step(0, '0);
    reset = 0;
    step(0, '0);

    // all clients requesting continuously up to the outstanding limit
    repeat (14) step(100, '1);
    bus.rsp_eop = 1; step(100, '1); bus.rsp_eop = 0;
    repeat (4) step(100, '1);
    flush();

    // single client saturating the limit
    repeat (12) step(100, 4'b0100);
    bus.rsp_eop = 1; step(100, 4'b0100); bus.rsp_eop = 0;
    repeat (4) step(100, 4'b0100);
    flush();

    // back-pressure window
    bus.tx_almostFull = 1; repeat (5) step(100, '1);
    bus.tx_almostFull = 0; repeat (3) step(100, '1);
    flush();

    // drain with outstanding requests, requests kept pending
    repeat (3) step(100, 4'b0001);
    step(0, '0);
    drain_req = 1;
    for (int k = 0; k < 12; k++) begin
      bus.rsp_eop = (m_cnt != 0) && (k % 2 == 1);
      step(100, '1);
    end
    bus.rsp_eop = 0;
    repeat (3) step(100, '1);
    drain_req = 0;
    repeat (3) step(100, '1);
    flush();

    // drain with nothing outstanding, then abort a drain mid-way
    drain_req = 1; repeat (4) step(0, '0);
    drain_req = 0; repeat (2) step(0, '0);
    repeat (3) step(100, '1);
    drain_req = 1; step(0, '0); step(0, '0);
    drain_req = 0; repeat (3) step(0, '0);
    flush();

    // response with nothing outstanding sets the sticky error
    bus.rsp_eop = 1; step(0, '0); bus.rsp_eop = 0;
    repeat (3) step(50, '1);
    flush();

    // randomized traffic with a reset in the middle
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) begin
        reset = 1; bus.rsp_eop = 0;
        step(50, '1); step(50, '1);
        reset = 0;
      end
      if ($urandom_range(99) < 3) drain_req = ~drain_req;
      bus.tx_almostFull = ($urandom_range(99) < 15);
      bus.rsp_eop = (m_cnt != 0) && ($urandom_range(99) < 35);
      step(50, '1);
    end

    flush();
    repeat (3) step(0, '0);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mpf_rd_req_arb.md
Name: mpf_rd_req_arb

Overview:
- Round-robin arbiter sharing one MPF read-request channel (c0 Tx) among N_CLIENTS AFU requesters.
- Limits outstanding reads to MAX_ACTIVE_REQS and obeys the channel almost-full back-pressure.
- Provides a drain/quiesce handshake: grants stop and the block waits for all responses, for use before VC remapping, fences or CSR reconfiguration.
- Sits between AFU client engines and the afu side of the MPF pipeline.

Parameters:
- N_CLIENTS, 4, number of requesters (2..16).
- MAX_ACTIVE_REQS, 512, maximum outstanding read requests (power of 2).
- ADDR_WIDTH, 42, cache-line address width.
- MDATA_WIDTH, 16, client metadata width passed through unchanged.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  N_CLIENTS  per-client request; held until granted
- req_addr  in  N_CLIENTS*ADDR_WIDTH  per-client address, client i at slice i
- req_mdata  in  N_CLIENTS*MDATA_WIDTH  per-client metadata
- req_grant  out  N_CLIENTS  one-hot acceptance pulse, combinational
- tx_almostFull  in  1  channel back-pressure
- tx_valid  out  1  registered read request
- tx_addr  out  ADDR_WIDTH  request address
- tx_mdata  out  MDATA_WIDTH  request metadata
- tx_client  out  $clog2(N_CLIENTS)  index of the issuing client
- rsp_eop  in  1  read-response end-of-packet; one per request
- drain_req  in  1  level request to quiesce
- drain_done  out  1  high while drained
- active_cnt  out  $clog2(MAX_ACTIVE_REQS)+1  outstanding count
- err_underflow  out  1  sticky; set by a response arriving with count 0
- stat_grant_cnt  out  N_CLIENTS*32  per-client grant counters (see Optional Feature)

Behaviour:
- Reset values: tx_valid=0, req_grant=0, drain_done=0, active_cnt=0, err_underflow=0, state=RUN, RR pointer=0 (client 0 has highest priority).
- Grant condition, evaluated each cycle: state==RUN && !tx_almostFull && (active_cnt + tx_valid) < MAX_ACTIVE_REQS && |req_valid.
  - Winner is the first valid client searching from ptr, ptr+1, ... modulo N_CLIENTS.
  - ptr becomes winner+1 (wrapping) on a grant only.
- Latency:
  - Grant in cycle T produces tx_valid=1 in cycle T+1, carrying that client's addr, mdata and index.
  - tx_valid is high for exactly one cycle per grant.
  - Back-to-back grants give a continuous tx_valid stream.
- Counter:
  - +1 when tx_valid=1; -1 when rsp_eop=1; unchanged when both or neither.
  - rsp_eop with active_cnt==0 and tx_valid==0: count holds at 0 and err_underflow is set; it clears only on reset.
  - The count never exceeds MAX_ACTIVE_REQS.
- State machine:
  - RUN -> DRAIN when drain_req=1. A grant already in flight (tx_valid next cycle) still issues; no new grant is made from the cycle drain_req is seen.
  - DRAIN -> DRAINED when active_cnt==0 && tx_valid==0. drain_done=1 from the next cycle.
  - DRAINED -> RUN when drain_req=0. drain_done drops in the same cycle; grants resume the following cycle.
  - DRAIN -> RUN if drain_req drops before completion; drain_done never asserts in that case.
- drain_req asserted with count already 0: drain_done asserts 2 cycles later.
- tx_almostFull blocks new grants only; an already-registered tx_valid is not withdrawn.
- Reset mid-operation: all state returns to reset values; outstanding responses after reset are counted as underflow.

Optional Feature:
- Macro MPF_RD_ARB_STATS_EN.
- Defined: per-client 32-bit grant counters, incremented on each req_grant bit, saturating at 0xFFFFFFFF, cleared by reset, driven on stat_grant_cnt.
- Undefined: no counters are built and stat_grant_cnt is tied to 0.

Test Plan:
- All 4 clients valid continuously after reset -> grants 0,1,2,3,0,... one per cycle; tx_client follows one cycle later; active_cnt rises by 1 per cycle.
- MAX_ACTIVE_REQS=8, no responses, client 2 valid -> exactly 8 tx_valid pulses then grants stop; one rsp_eop -> exactly one further grant.
- tx_almostFull=1 for 5 cycles with requests pending -> no req_grant during those cycles; grants resume the cycle after deassertion.
- 3 outstanding, drain_req=1 -> no grants; drain_done rises the cycle after the 3rd rsp_eop; drain_req=0 -> drain_done=0 and a grant the next cycle.
- Simultaneous tx_valid and rsp_eop at count 5 -> count stays 5; rsp_eop at count 0 -> err_underflow=1 and count stays 0.
- With MPF_RD_ARB_STATS_EN, 10 grants to client 1 -> stat slice 1 reads 10 and other slices read 0; without the macro all slices read 0.
